// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10,
    RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    WRITE,
    RESP
  } state_e;

  // Pull the addressed byte/half out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input size_e       size,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      BYTE:    r = {{24{~uns & b[7]}}, b};
      HALF:    r = {{16{~uns & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Overlay the low byte/half of new_data onto old at the addressed lane.
  function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                             input logic [31:0] new_data,
                                             input logic [1:0]  off,
                                             input size_e       size);
    logic [31:0] r;
    r = old;
    case (size)
      BYTE:    r[{off, 3'b000} +: 8]     = new_data[7:0];
      HALF:    r[{off[1], 4'b0000} +: 16] = new_data[15:0];
      default: r = new_data;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake between the execute stage and the load/store unit.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane extraction (loads) and lane merge (sub-word stores).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        uns,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  assign load_data = lane_extract(rd_word, off, size, uns);
  assign merged    = lane_merge(rd_word, new_data, off, size);
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: alignment/range checks, load formatting, RMW sub-word stores.
// Optional event counters enabled by defining LSU_STATS_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 10
) (
  input  logic        clk,
  input  logic        reset,
  lsu_if.slave        bus,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic [15:0] stat_loads,
  output logic [15:0] stat_stores,
  output logic [15:0] stat_errs
);

  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  state_e      state_q, state_d;
  logic        we_q, uns_q;
  size_e       size_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wr_data_q;

  size_e       req_size;
  logic        req_err;
  logic        accept;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign req_size = size_e'(bus.req_size);
  assign req_err  = (req_size == RSVD)
                  | ((req_size == HALF) && bus.req_addr[0])
                  | ((req_size == WORD) && (bus.req_addr[1:0] != 2'b00))
                  | (bus.req_addr[31:2] >= WORD_LIMIT);
  assign accept   = bus.req_valid && (state_q == IDLE);

  lsu_align u_align (
    .rd_word   (mem_read_data),
    .new_data  (wdata_q),
    .off       (off_q),
    .size      (size_q),
    .uns       (uns_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_err ? RESP : ACCESS;
      ACCESS:  state_d = (we_q && size_q == WORD) ? RESP : CAPTURE;
      CAPTURE: state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write strobe comes purely from registered state so it is steady across the negedge.
  assign mem_write = ((state_q == ACCESS) && we_q && (size_q == WORD)) || (state_q == WRITE);

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wr_data_q;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= BYTE;
      off_q     <= 2'b00;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        size_q  <= req_size;
        off_q   <= bus.req_addr[1:0];
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
        err_q   <= req_err;
        if (!req_err) begin
          addr_q <= {bus.req_addr[31:2], 2'b00};
          if (bus.req_we && req_size == WORD) wr_data_q <= bus.req_wdata;
        end
      end
      if (state_q == CAPTURE) begin
        if (we_q) wr_data_q <= merged;
        else      rdata_q   <= load_data;
      end
    end
  end

`ifdef LSU_STATS_EN
  logic        resp_done;
  logic [15:0] loads_q, stores_q, errs_q;

  assign resp_done = bus.resp_valid && bus.resp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loads_q  <= '0;
      stores_q <= '0;
      errs_q   <= '0;
    end else if (resp_done) begin
      if (err_q)     errs_q   <= sat_inc(errs_q);
      else if (we_q) stores_q <= sat_inc(stores_q);
      else           loads_q  <= sat_inc(loads_q);
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_errs   = errs_q;
`else
  assign stat_loads  = '0;
  assign stat_stores = '0;
  assign stat_errs   = '0;
`endif

endmodule
